// File: rtl/reg_writeback_if.sv
// Write-back request/drain/forwarding bundle between the load/ALU producers,
// the write-back queue and the register file.
interface reg_writeback_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
);
  logic              LD_VALID;
  logic [AWIDTH-1:0] LD_RD;
  logic [DWIDTH-1:0] LD_DATA;
  logic              LD_READY;
  logic              ALU_VALID;
  logic [AWIDTH-1:0] ALU_RD;
  logic [DWIDTH-1:0] ALU_DATA;
  logic              ALU_READY;
  logic              HOLD;
  logic              WE;
  logic [AWIDTH-1:0] WA;
  logic [DWIDTH-1:0] WD;
  logic [AWIDTH-1:0] FWD_RA;
  logic              FWD_HIT;
  logic [DWIDTH-1:0] FWD_DATA;
  logic              BUSY;

  modport master (
    output LD_VALID, LD_RD, LD_DATA, ALU_VALID, ALU_RD, ALU_DATA, HOLD, FWD_RA,
    input  LD_READY, ALU_READY, WE, WA, WD, FWD_HIT, FWD_DATA, BUSY
  );

  modport slave (
    input  LD_VALID, LD_RD, LD_DATA, ALU_VALID, ALU_RD, ALU_DATA, HOLD, FWD_RA,
    output LD_READY, ALU_READY, WE, WA, WD, FWD_HIT, FWD_DATA, BUSY
  );
endinterface

// File: rtl/reg_writeback.sv
// Write-back queue: merges load and ALU results (load has priority) into an
// in-order FIFO drained to the register file, with youngest-match forwarding.
module reg_writeback #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int DEPTH  = 4
) (
  input logic           CLK,
  input logic           RST,
  reg_writeback_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AWIDTH-1:0] rd_q   [DEPTH];
  logic [DWIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic              full, empty;
  logic              ld_rdy, alu_rdy;
  logic              push_vld, push_en, pop;
  logic [AWIDTH-1:0] push_rd;
  logic [DWIDTH-1:0] push_dat;
  logic              fwd_hit;
  logic [DWIDTH-1:0] fwd_dat;
  logic [PW-1:0]     idx;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign ld_rdy  = !full;
  assign alu_rdy = !full && !bus.LD_VALID;
  assign pop     = !empty && !bus.HOLD;

  always_comb begin
    push_vld = 1'b0;
    push_rd  = '0;
    push_dat = '0;
    if (bus.LD_VALID && ld_rdy) begin
      push_vld = 1'b1;
      push_rd  = bus.LD_RD;
      push_dat = bus.LD_DATA;
    end else if (bus.ALU_VALID && alu_rdy) begin
      push_vld = 1'b1;
      push_rd  = bus.ALU_RD;
      push_dat = bus.ALU_DATA;
    end
  end

  // x0 writes complete the handshake but never occupy a slot.
  assign push_en = push_vld && (push_rd != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push_en) begin
      tail_d = tail_q + PW'(1);
    end
    case ({push_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_dat = '0;
    idx     = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (bus.FWD_RA != '0) && (rd_q[idx] == bus.FWD_RA)) begin
        fwd_hit = 1'b1;
        fwd_dat = data_q[idx];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && push_en) begin
      rd_q[tail_q]   <= push_rd;
      data_q[tail_q] <= push_dat;
    end
  end

  assign bus.LD_READY  = ld_rdy;
  assign bus.ALU_READY = alu_rdy;
  assign bus.WE        = pop;
  assign bus.WA        = empty ? '0 : rd_q[head_q];
  assign bus.WD        = empty ? '0 : data_q[head_q];
  assign bus.FWD_HIT   = fwd_hit;
  assign bus.FWD_DATA  = fwd_dat;
  assign bus.BUSY      = !empty;
endmodule

// File: tb/tb_reg_writeback.sv
// Randomised and directed bench for reg_writeback against a queue-based model.
module tb_reg_writeback;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  reg_writeback_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  reg_writeback #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  ent_t mq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                       input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input logic hold, input logic [AW-1:0] ra);
    bus.LD_VALID  = lv;
    bus.LD_RD     = lrd;
    bus.LD_DATA   = ld;
    bus.ALU_VALID = av;
    bus.ALU_RD    = ard;
    bus.ALU_DATA  = ad;
    bus.HOLD      = hold;
    bus.FWD_RA    = ra;
  endtask

  // One clock: check outputs against the model at the falling edge, then
  // advance the model at the rising edge using the same held inputs.
  task automatic step();
    bit            full, ld_acc, alu_acc, exp_we, exp_hit;
    logic [AW-1:0] exp_wa;
    logic [DW-1:0] exp_wd, exp_fd;
    @(negedge CLK);
    full    = (mq.size() == DEPTH);
    ld_acc  = bus.LD_VALID && !full;
    alu_acc = bus.ALU_VALID && !full && !bus.LD_VALID;
    exp_we  = (mq.size() > 0) && !bus.HOLD;
    exp_wa  = (mq.size() > 0) ? mq[0].rd : '0;
    exp_wd  = (mq.size() > 0) ? mq[0].data : '0;
    exp_hit = 1'b0;
    exp_fd  = '0;
    if (bus.FWD_RA != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].rd == bus.FWD_RA) begin
          exp_hit = 1'b1;
          exp_fd  = mq[i].data;
          break;
        end
      end
    end
    check("ld_ready",  64'(bus.LD_READY),  64'(!full));
    check("alu_ready", 64'(bus.ALU_READY), 64'(!full && !bus.LD_VALID));
    check("we",        64'(bus.WE),        64'(exp_we));
    check("wa",        64'(bus.WA),        64'(exp_wa));
    check("wd",        64'(bus.WD),        64'(exp_wd));
    check("busy",      64'(bus.BUSY),      64'(mq.size() > 0));
    check("fwd_hit",   64'(bus.FWD_HIT),   64'(exp_hit));
    check("fwd_data",  64'(bus.FWD_DATA),  64'(exp_fd));
    @(posedge CLK);
    if (RST) begin
      mq.delete();
    end else begin
      if (exp_we) void'(mq.pop_front());
      if (ld_acc && bus.LD_RD != 0) mq.push_back('{rd: bus.LD_RD, data: bus.LD_DATA});
      else if (alu_acc && bus.ALU_RD != 0) mq.push_back('{rd: bus.ALU_RD, data: bus.ALU_DATA});
    end
    #1;
  endtask

  task automatic idle(input logic hold);
    drive(0, '0, '0, 0, '0, '0, hold, '0);
  endtask

  initial begin
    RST = 1'b1;
    idle(0);
    step();
    step();
    RST = 1'b0;
    #1;
    check("rst_we",      64'(bus.WE),       64'd0);
    check("rst_busy",    64'(bus.BUSY),     64'd0);
    check("rst_ldready", 64'(bus.LD_READY), 64'd1);

    // Single ALU write, one-cycle latency to WE.
    drive(0, '0, '0, 1, 5'd5, 32'hDEAD_BEEF, 0, '0);
    step();
    idle(0);
    #1;
    check("s1_we", 64'(bus.WE), 64'd1);
    check("s1_wa", 64'(bus.WA), 64'd5);
    check("s1_wd", 64'(bus.WD), 64'hDEAD_BEEF);
    step();
    check("s1_busy", 64'(bus.BUSY), 64'd0);

    // Load beats ALU in the same cycle; ALU goes in on the next edge.
    drive(1, 5'd3, 32'h100, 1, 5'd4, 32'h200, 0, '0);
    #1;
    check("pri_alu_rdy", 64'(bus.ALU_READY), 64'd0);
    step();
    drive(0, '0, '0, 1, 5'd4, 32'h200, 0, '0);
    #1;
    check("pri_wa_ld", 64'(bus.WA), 64'd3);
    step();
    idle(0);
    #1;
    check("pri_wa_alu", 64'(bus.WA), 64'd4);
    step();
    step();

    // x0 destination is acknowledged and dropped.
    drive(1, 5'd0, 32'hFFFF_FFFF, 0, '0, '0, 0, '0);
    step();
    idle(0);
    step();
    check("x0_busy", 64'(bus.BUSY), 64'd0);

    // Fill while held, then drain in order and push again across the wrap.
    for (int r = 1; r <= 4; r++) begin
      drive(1, AW'(r), DW'(32'hA0 + r), 0, '0, '0, 1, '0);
      step();
    end
    idle(1);
    #1;
    check("full_ldready", 64'(bus.LD_READY), 64'd0);
    step();
    idle(0);
    for (int r = 1; r <= 4; r++) begin
      #1;
      check("drain_wa", 64'(bus.WA), 64'(r));
      step();
    end
    for (int r = 9; r <= 11; r++) begin
      drive(1, AW'(r), DW'(32'hB0 + r), 0, '0, '0, 0, '0);
      step();
    end
    idle(0);
    repeat (3) step();

    // Forwarding picks the youngest matching entry.
    drive(0, '0, '0, 1, 5'd7, 32'h11, 1, '0);
    step();
    drive(0, '0, '0, 1, 5'd7, 32'h22, 1, '0);
    step();
    idle(1);
    bus.FWD_RA = 5'd7;
    #1;
    check("fwd7_hit",  64'(bus.FWD_HIT),  64'd1);
    check("fwd7_data", 64'(bus.FWD_DATA), 64'h22);
    bus.FWD_RA = 5'd0;
    #1;
    check("fwd0_hit",  64'(bus.FWD_HIT),  64'd0);
    step();

    // Reset discards held entries; nothing drains afterwards.
    drive(1, 5'd12, 32'h33, 0, '0, '0, 1, '0);
    step();
    idle(1);
    check("pre_rst_busy", 64'(bus.BUSY), 64'd1);
    RST = 1'b1;
    drive(1, 5'd13, 32'h44, 0, '0, '0, 1, '0);
    step();
    RST = 1'b0;
    idle(1);
    #1;
    check("post_rst_busy", 64'(bus.BUSY), 64'd0);
    check("post_rst_we",   64'(bus.WE),   64'd0);
    step();
    idle(0);
    repeat (3) step();

    // Randomised traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      RST = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), $urandom(),
            $urandom_range(0, 1) == 0, AW'($urandom_range(0, 7)), $urandom(),
            $urandom_range(0, 3) == 0, AW'($urandom_range(0, 7)));
      step();
    end
    RST = 1'b0;
    idle(0);
    repeat (6) step();
    check("final_busy", 64'(bus.BUSY), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, data width of each write-back value.
REQ-002 The block SHALL have parameter AWIDTH, default 5, register-index width.
REQ-003 The block SHALL have parameter DEPTH, default 4, pending-write queue entries; power of two, at least 2.
REQ-004 The block SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port LD_VALID  input  1  load-unit write-back request.
REQ-007 The block SHALL have port LD_RD  input  AWIDTH  load destination register.
REQ-008 The block SHALL have port LD_DATA  input  DWIDTH  load result.
REQ-009 The block SHALL have port LD_READY  output  1  load request accepted when LD_VALID and LD_READY are both high.
REQ-010 The block SHALL have ports ALU_VALID, ALU_RD, ALU_DATA (inputs) and ALU_READY (output), with the same widths and meaning for the ALU source.
REQ-011 The block SHALL have port HOLD  input  1  when high, blocks draining to the register file.
REQ-012 The block SHALL have ports WE  output  1, WA  output  AWIDTH, WD  output  DWIDTH, which drive the register-file write port.
REQ-013 The block SHALL have port FWD_RA  input  AWIDTH  forwarding lookup index.
REQ-014 The block SHALL have ports FWD_HIT  output  1 and FWD_DATA  output  DWIDTH, the forwarding result.
REQ-015 The block SHALL have port BUSY  output  1, high when the queue is non-empty.

Function
REQ-016 Queue: DEPTH-entry circular FIFO of {rd, data}, with head/tail pointers wrapping modulo DEPTH and a count of 0..DEPTH.
REQ-017 LD_READY SHALL equal !full; ALU_READY SHALL equal !full && !LD_VALID, so the load source has fixed priority and at most one push occurs per cycle.
REQ-018 An accepted request with rd==0 SHALL complete the handshake and be dropped (not enqueued, count unchanged).
REQ-019 An accepted request with rd!=0 SHALL be written at the tail on the accepting edge, then tail++ and count++.
REQ-020 WE SHALL equal !empty && !HOLD, combinationally; WA/WD SHALL present the head entry, and WA/WD SHALL be 0 when the queue is empty.
REQ-021 On every edge with WE high the head SHALL pop (head++, count--); no pop SHALL occur while HOLD is high.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; push while full is impossible by REQ-017.
REQ-023 Latency: request accepted at edge N on an empty queue with HOLD low -> WE high during cycle N+1 -> register file written at edge N+1.
REQ-024 Ordering: writes SHALL reach WE in acceptance order, including two writes to the same rd.
REQ-025 FWD_HIT SHALL be 1 iff FWD_RA!=0 and some queued entry has rd==FWD_RA; FWD_DATA SHALL be the data of the youngest such entry, else 0; the lookup is combinational and excludes same-cycle incoming requests.
REQ-026 No arithmetic beyond pointer/count increments; all widths are exact and there is no truncation of data.

Reset
REQ-027 With RST high at an edge: head=tail=count=0 and all queued entries are discarded, including entries pending mid-drain.
REQ-028 During the cycle after reset: WE=0, WA=0, WD=0, BUSY=0, FWD_HIT=0, FWD_DATA=0, LD_READY=1, ALU_READY=!LD_VALID.
REQ-029 Requests presented in a cycle where RST is high SHALL NOT be enqueued.

Verification
REQ-030 Single write: ALU_VALID with rd=5, data=0xDEAD_BEEF at edge 0 -> WE=1, WA=5, WD=0xDEADBEEF during cycle 1, BUSY low after edge 1.
REQ-031 Priority: LD (rd=3, 0x100) and ALU (rd=4, 0x200) valid together -> ALU_READY=0; LD is written first, ALU is accepted on the next edge and written one cycle later.
REQ-032 x0 drop: LD_VALID with rd=0, data=0xFFFF_FFFF -> LD_READY=1, BUSY stays 0, WE never rises.
REQ-033 Full/wrap: with HOLD=1, push 4 writes (rd=1..4) -> LD_READY=0; release HOLD -> WE on 4 consecutive cycles, WA=1,2,3,4; then push 3 more to confirm pointer wrap and ordering.
REQ-034 Forwarding: with HOLD=1, queue rd=7/0x11 then rd=7/0x22 -> FWD_RA=7 gives HIT=1, DATA=0x22; FWD_RA=0 gives HIT=0.
REQ-035 Reset mid-operation: 3 entries queued with HOLD=1, then RST pulsed -> BUSY=0 and WE=0 next cycle; after HOLD is released, no write occurs.
